// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls, branch
// redirect flushes, data-memory waits, plus saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_busy,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rem_q, rem_d;
    logic [7:0]  wait_cnt;
    logic        load_use;

    assign state = state_q;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_busy   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        state_d      = state_q;
        rem_d        = rem_q;
        if (reset) begin
            state_d = RUN;
            rem_d   = 4'd0;
        end else if (dmem_busy) begin
            // Whole pipeline freezes; a pending branch stays in EX until memory completes.
            if_id_busy  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            case (state_q)
                RUN, MEM_WAIT: state_d = MEM_WAIT;
                FLUSH:         state_d = FLUSH;
                default:       state_d = RUN;
            endcase
        end else if (state_q == FLUSH) begin
            pc_en        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (rem_q <= 4'd1) begin
                state_d = RUN;
                rem_d   = 4'd0;
            end else begin
                rem_d = rem_q - 4'd1;
            end
        end else begin
            // RUN, MEM_WAIT (memory just completed) and the illegal encoding all decode as RUN.
            state_d = RUN;
            if (branch_taken) begin
                pc_en        = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    rem_d   = 4'(FLUSH_CYCLES - 1);
                end
            end else if (load_use) begin
                if_id_busy   = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            rem_q       <= 4'd0;
            wait_cnt    <= 8'd0;
            stall_count <= '0;
            flush_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (dmem_busy) begin
                if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt == 8'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (!pc_en && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two differently parameterised instances share stimulus and
// are compared each cycle against a cycle-level model of the pipeline rules.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, dmem_busy;

    logic [1:0] pc_en, if_id_busy, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_timeout;
    logic [1:0] st [2];
    logic [15:0] stc_a, flc_a;
    logic [3:0]  stc_b, flc_b;

    int total = 0;
    int bad   = 0;

    int fc[2]   = '{2, 4};
    int mt[2]   = '{4, 6};
    int cmax[2] = '{65535, 15};

    // Model: flush cycles still owed after the current one, busy run length, waiting flag.
    int m_fl[2], m_run[2], m_stall[2], m_flush[2];
    bit m_wait[2], m_tmo[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_en(pc_en[0]), .if_id_busy(if_id_busy[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_hold(id_ex_hold[0]), .id_ex_bubble(id_ex_bubble[0]), .ex_mem_hold(ex_mem_hold[0]),
        .state(st[0]), .stall_count(stc_a), .flush_count(flc_a), .mem_timeout(mem_timeout[0])
    );

    hazard_ctrl #(.FLUSH_CYCLES(4), .MEM_TIMEOUT(6), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_en(pc_en[1]), .if_id_busy(if_id_busy[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_hold(id_ex_hold[1]), .id_ex_bubble(id_ex_bubble[1]), .ex_mem_hold(ex_mem_hold[1]),
        .state(st[1]), .stall_count(stc_b), .flush_count(flc_b), .mem_timeout(mem_timeout[1])
    );

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    function automatic logic [5:0] obs_ctl(input int i);
        return {pc_en[i], if_id_busy[i], if_id_flush[i], id_ex_hold[i], id_ex_bubble[i], ex_mem_hold[i]};
    endfunction

    // Expected controls, ordered {pc_en, if_id_busy, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold}.
    function automatic logic [5:0] exp_ctl(input int i);
        logic hit;
        hit = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (reset)             return 6'b000000;
        if (dmem_busy)         return 6'b010101;
        if (m_fl[i] > 0)       return 6'b101010;
        if (branch_taken)      return 6'b101010;
        if (hit)               return 6'b010010;
        return 6'b100000;
    endfunction

    function automatic logic [31:0] obs_stall(input int i);
        return (i == 0) ? 32'(stc_a) : 32'(stc_b);
    endfunction

    function automatic logic [31:0] obs_flush(input int i);
        return (i == 0) ? 32'(flc_a) : 32'(flc_b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 0; m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            m_wait[i] = 0; m_tmo[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("ctl", i, 32'(obs_ctl(i)), 32'(exp_ctl(i)));
            chk("state", i, 32'(st[i]), (m_fl[i] > 0) ? 32'd2 : (m_wait[i] ? 32'd1 : 32'd0));
            chk("stall_count", i, obs_stall(i), 32'(m_stall[i]));
            chk("flush_count", i, obs_flush(i), 32'(m_flush[i]));
            chk("mem_timeout", i, 32'(mem_timeout[i]), 32'(m_tmo[i]));
        end
    endtask

    task automatic model_update();
        logic [5:0] e;
        for (int i = 0; i < 2; i++) begin
            e = exp_ctl(i);
            if (dmem_busy) begin
                if (m_fl[i] == 0) m_wait[i] = 1;
                if (m_run[i] < 255) m_run[i]++;
                if (m_run[i] >= mt[i]) m_tmo[i] = 1;
            end else begin
                m_run[i]  = 0;
                m_wait[i] = 0;
                if (m_fl[i] > 0) m_fl[i]--;
                else if (branch_taken) m_fl[i] = fc[i] - 1;
            end
            if (!e[5] && m_stall[i] < cmax[i]) m_stall[i]++;
            if (e[3] && m_flush[i] < cmax[i]) m_flush[i]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_state", 0, 32'(st[0]), 32'd0);
        chk("rst_state", 1, 32'(st[1]), 32'd0);
        chk("rst_flush", 1, 32'(flc_b), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load-use hazard: one bubble, then no stall with rd=x0 or unused rs1.
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        chk("lu_pc_en", 0, 32'(pc_en[0]), 32'd0);
        tick();
        idle();
        #1;
        chk("lu_stall", 0, 32'(stc_a), 32'd1);
        chk("lu_state", 0, 32'(st[0]), 32'd0);
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        tick();
        ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0;
        #1;
        chk("lu_unused", 0, 32'(pc_en[0]), 32'd1);
        tick();
        ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        tick();
        idle();

        // Taken branch with FLUSH_CYCLES=2 on instance a.
        branch_taken = 1;
        tick();
        branch_taken = 0;
        #1;
        chk("br_state_t1", 0, 32'(st[0]), 32'd2);
        tick();
        #1;
        chk("br_state_t2", 0, 32'(st[0]), 32'd0);
        chk("br_flush", 0, 32'(flc_a), 32'd2);
        repeat (4) tick();

        // Three-cycle memory wait.
        dmem_busy = 1;
        repeat (3) tick();
        dmem_busy = 0;
        #1;
        chk("mw_state", 0, 32'(st[0]), 32'd1);
        tick();
        chk("mw_state_end", 0, 32'(st[0]), 32'd0);
        chk("mw_stall", 0, 32'(stc_a), 32'd5);

        // Busy and branch together: flush waits for memory.
        dmem_busy = 1; branch_taken = 1;
        repeat (2) tick();
        dmem_busy = 0;
        #1;
        chk("bb_flush", 0, 32'(if_id_flush[0]), 32'd1);
        tick();
        branch_taken = 0;
        repeat (5) tick();

        // Timeout: six busy cycles, flag sticky afterwards.
        dmem_busy = 1;
        repeat (6) tick();
        dmem_busy = 0;
        repeat (2) tick();
        chk("tmo_sticky", 0, 32'(mem_timeout[0]), 32'd1);
        chk("tmo_sticky", 1, 32'(mem_timeout[1]), 32'd1);

        // Reset in the 2nd flush cycle of instance b, then a full 4-cycle flush.
        branch_taken = 1;
        tick();
        branch_taken = 0;
        async_reset();
        branch_taken = 1;
        tick();
        branch_taken = 0;
        repeat (5) tick();
        chk("rst_reflush", 1, 32'(flc_b), 32'd4);
        chk("rst_reflush", 0, 32'(flc_a), 32'd2);

        // Randomized traffic with small register indices for frequent hazard hits.
        for (int n = 0; n < 600; n++) begin
            dmem_busy    = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) async_reset();
            tick();
        end
        idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
